// File: rtl/spmv_csr_engine_pkg.sv
// Shared types and sizing helpers for the CSR sparse matrix-vector engine.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package spmv_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_N_ROWS  = 16;
    localparam int DEF_VEC_LEN = 16;
    localparam int DEF_NNZ_MAX = 256;
    localparam int DEF_ACC_W   = 40;
    localparam int DEF_OUT_W   = 16;

    // Bits needed to index n distinct items.
    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

    // Bits needed to hold the values 0..n inclusive (pointers and bounds).
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LO,
        ST_HI,
        ST_CHK,
        ST_NZ,
        ST_XR,
        ST_MAC,
        ST_WR,
        ST_DONE
    } state_t;

endpackage

// File: rtl/spmv_csr_engine_if.sv
// SRAM-side bus of the engine: row_ptr, nonzero and x read ports plus y write port.
// Latency: every read returns its data the cycle after the strobe.
// Backpressure: none; the memories are always ready.
interface spmv_csr_engine_if #(
    parameter int DATA_W  = spmv_pkg::DEF_DATA_W,
    parameter int N_ROWS  = spmv_pkg::DEF_N_ROWS,
    parameter int VEC_LEN = spmv_pkg::DEF_VEC_LEN,
    parameter int NNZ_MAX = spmv_pkg::DEF_NNZ_MAX,
    parameter int OUT_W   = spmv_pkg::DEF_OUT_W
);
    localparam int RA_W  = spmv_pkg::cnt_w(N_ROWS);
    localparam int RP_W  = spmv_pkg::cnt_w(NNZ_MAX);
    localparam int NZA_W = spmv_pkg::idx_w(NNZ_MAX);
    localparam int CI_W  = spmv_pkg::idx_w(VEC_LEN);
    localparam int YA_W  = spmv_pkg::idx_w(N_ROWS);

    logic              o_rp_rd;
    logic [RA_W-1:0]   o_rp_addr;
    logic [RP_W-1:0]   i_rp_data;
    logic              o_nz_rd;
    logic [NZA_W-1:0]  o_nz_addr;
    logic [DATA_W-1:0] i_val;
    logic [CI_W-1:0]   i_col;
    logic              o_x_rd;
    logic [CI_W-1:0]   o_x_addr;
    logic [DATA_W-1:0] i_x;
    logic              o_y_we;
    logic [YA_W-1:0]   o_y_addr;
    logic [OUT_W-1:0]  o_y_data;

    modport master (
        output o_rp_rd, o_rp_addr, o_nz_rd, o_nz_addr, o_x_rd, o_x_addr,
               o_y_we, o_y_addr, o_y_data,
        input  i_rp_data, i_val, i_col, i_x
    );

    modport slave (
        input  o_rp_rd, o_rp_addr, o_nz_rd, o_nz_addr, o_x_rd, o_x_addr,
               o_y_we, o_y_addr, o_y_data,
        output i_rp_data, i_val, i_col, i_x
    );
endinterface

// File: rtl/spmv_csr_engine_mac.sv
// Signed multiply-accumulate with result narrowing; saturating when SPMV_SAT_EN is defined.
// Latency: accumulator updates one cycle after i_en; o_y_next is the narrowed next-cycle value.
// Backpressure: none; i_clr has priority over i_en.
module spmv_mac #(
    parameter int DATA_W = spmv_pkg::DEF_DATA_W,
    parameter int ACC_W  = spmv_pkg::DEF_ACC_W,
    parameter int OUT_W  = spmv_pkg::DEF_OUT_W
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [OUT_W-1:0]  o_y_next
);
    localparam int PROD_W = 2 * DATA_W;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  acc_q;

`ifdef SPMV_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MAX   = ACC_W'((2 ** (OUT_W - 1)) - 1);
    logic signed [ACC_W:0] sum;
`else
    logic signed [ACC_W-1:0] sum;
`endif

    // Product, accumulate (wrapping or saturating) and narrow the value the accumulator is about to hold.
    always_comb begin
        prod = $signed(i_a) * $signed(i_b);
`ifdef SPMV_SAT_EN
        sum = (ACC_W+1)'(acc_q) + (ACC_W+1)'(prod);
        // One extra sign bit disagreeing with the top result bit means the signed range was left.
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            acc_sum = sum[ACC_W] ? ~ACC_MAX : ACC_MAX;
        end else begin
            acc_sum = sum[ACC_W-1:0];
        end
`else
        sum     = acc_q + ACC_W'(prod);
        acc_sum = sum;
`endif
        acc_d = acc_q;
        if (i_clr) begin
            acc_d = '0;
        end else if (i_en) begin
            acc_d = acc_sum;
        end
`ifdef SPMV_SAT_EN
        if (acc_d > Y_MAX) begin
            o_y_next = Y_MAX[OUT_W-1:0];
        end else if (acc_d < ~Y_MAX) begin
            o_y_next = ~Y_MAX[OUT_W-1:0];
        end else begin
            o_y_next = acc_d[OUT_W-1:0];
        end
`else
        o_y_next = acc_d[OUT_W-1:0];
`endif
    end

    // Accumulator register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
endmodule

// File: rtl/spmv_csr_engine.sv
// CSR sparse matrix times dense vector, one result row written per row; SPMV_SAT_EN selects saturation.
// Latency: 3 cycles per row boundary plus 3 cycles per nonzero, then a one-cycle o_done.
// Backpressure: none; i_start is ignored while o_busy is high, o_err is sticky until the next start.
module spmv_csr_engine
    import spmv_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int N_ROWS  = DEF_N_ROWS,
    parameter int VEC_LEN = DEF_VEC_LEN,
    parameter int NNZ_MAX = DEF_NNZ_MAX,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int OUT_W   = DEF_OUT_W
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_start,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err,
    spmv_csr_engine_if.master  mem
);
    localparam int RA_W  = cnt_w(N_ROWS);
    localparam int RP_W  = cnt_w(NNZ_MAX);
    localparam int NZA_W = idx_w(NNZ_MAX);
    localparam int CI_W  = idx_w(VEC_LEN);
    localparam int YA_W  = idx_w(N_ROWS);

    state_t            state_q, state_d;
    logic [RA_W-1:0]   r_q, r_d;
    logic [RP_W-1:0]   k_q, k_d;
    logic [RP_W-1:0]   end_q, end_d;
    logic [DATA_W-1:0] val_q, val_d;
    logic              first_q, first_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rp_rd_q, rp_rd_d;
    logic [RA_W-1:0]   rp_addr_q, rp_addr_d;
    logic              nz_rd_q, nz_rd_d;
    logic [NZA_W-1:0]  nz_addr_q, nz_addr_d;
    logic              x_rd_q, x_rd_d;
    logic [CI_W-1:0]   x_addr_q, x_addr_d;
    logic              y_we_q, y_we_d;
    logic [YA_W-1:0]   y_addr_q, y_addr_d;
    logic [OUT_W-1:0]  y_data_q, y_data_d;
    logic              acc_clr, acc_en;
    logic [OUT_W-1:0]  y_next;

    spmv_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .OUT_W  (OUT_W)
    ) u_mac (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_clr    (acc_clr),
        .i_en     (acc_en),
        .i_a      (val_q),
        .i_b      (mem.i_x),
        .o_y_next (y_next)
    );

    // Next state, row/nonzero pointers, and the registered strobes for the state being entered.
    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        k_d       = k_q;
        end_d     = end_q;
        val_d     = val_q;
        first_d   = first_q;
        err_d     = err_q;
        rp_addr_d = rp_addr_q;
        nz_addr_d = nz_addr_q;
        x_addr_d  = x_addr_q;
        y_addr_d  = y_addr_q;
        y_data_d  = y_data_q;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_LO;
                    r_d     = '0;
                    err_d   = 1'b0;
                    acc_clr = 1'b1;
                end
            end
            ST_LO: begin
                state_d = ST_HI;
                first_d = 1'b1;
            end
            ST_HI: begin
                // Only the very first HI sees rp[0]; later rows start where the previous one ended.
                if (first_q) begin
                    k_d = mem.i_rp_data;
                end
                first_d = 1'b0;
                state_d = ST_CHK;
            end
            ST_CHK: begin
                if (mem.i_rp_data == k_q) begin
                    end_d   = k_q;
                    state_d = ST_WR;
                end else if (mem.i_rp_data < k_q) begin
                    // Descending row pointer: emit 0 for this row and resume from the current k.
                    err_d   = 1'b1;
                    end_d   = k_q;
                    state_d = ST_WR;
                end else begin
                    end_d   = mem.i_rp_data;
                    state_d = ST_NZ;
                end
            end
            ST_NZ: begin
                state_d = ST_XR;
            end
            ST_XR: begin
                val_d    = mem.i_val;
                x_addr_d = mem.i_col;
                state_d  = ST_MAC;
            end
            ST_MAC: begin
                acc_en  = 1'b1;
                k_d     = k_q + RP_W'(1);
                state_d = (k_d == end_q) ? ST_WR : ST_NZ;
            end
            ST_WR: begin
                acc_clr = 1'b1;
                r_d     = r_q + RA_W'(1);
                state_d = (r_q == RA_W'(N_ROWS - 1)) ? ST_DONE : ST_HI;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rp_rd_d = (state_d == ST_LO) || (state_d == ST_HI);
        nz_rd_d = (state_d == ST_NZ);
        x_rd_d  = (state_d == ST_XR);
        y_we_d  = (state_d == ST_WR);
        done_d  = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE);
        if (state_d == ST_LO) begin
            rp_addr_d = '0;
        end
        if (state_d == ST_HI) begin
            rp_addr_d = r_d + RA_W'(1);
        end
        if (state_d == ST_NZ) begin
            nz_addr_d = k_d[NZA_W-1:0];
        end
        if (state_d == ST_WR) begin
            y_addr_d = r_d[YA_W-1:0];
            y_data_d = y_next;
        end
    end

    // State and output registers; reset lands in IDLE with every strobe low and nothing written.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= ST_IDLE;
            r_q       <= '0;
            k_q       <= '0;
            end_q     <= '0;
            val_q     <= '0;
            first_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rp_rd_q   <= 1'b0;
            rp_addr_q <= '0;
            nz_rd_q   <= 1'b0;
            nz_addr_q <= '0;
            x_rd_q    <= 1'b0;
            x_addr_q  <= '0;
            y_we_q    <= 1'b0;
            y_addr_q  <= '0;
            y_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            k_q       <= k_d;
            end_q     <= end_d;
            val_q     <= val_d;
            first_q   <= first_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rp_rd_q   <= rp_rd_d;
            rp_addr_q <= rp_addr_d;
            nz_rd_q   <= nz_rd_d;
            nz_addr_q <= nz_addr_d;
            x_rd_q    <= x_rd_d;
            x_addr_q  <= x_addr_d;
            y_we_q    <= y_we_d;
            y_addr_q  <= y_addr_d;
            y_data_q  <= y_data_d;
        end
    end

    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_err         = err_q;
    assign mem.o_rp_rd   = rp_rd_q;
    assign mem.o_rp_addr = rp_addr_q;
    assign mem.o_nz_rd   = nz_rd_q;
    assign mem.o_nz_addr = nz_addr_q;
    assign mem.o_x_rd    = x_rd_q;
    // The column index only arrives during XR, so the x address bypasses its register in that state.
    assign mem.o_x_addr  = (state_q == ST_XR) ? mem.i_col : x_addr_q;
    assign mem.o_y_we    = y_we_q;
    assign mem.o_y_addr  = y_addr_q;
    assign mem.o_y_data  = y_data_q;
endmodule

// File: tb/tb_spmv_csr_engine.sv
// Self-checking bench for spmv_csr_engine against a row-by-row CSR reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (memories answer every read the following cycle).
module tb_spmv_csr_engine;
    logic clk = 1'b0;
    logic rstn;
    logic start;
    logic busy, done, err;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   start_edge;

    logic [8:0]         rp_mem  [0:16];
    logic signed [15:0] val_mem [0:255];
    logic [3:0]         col_mem [0:255];
    logic signed [15:0] x_mem   [0:15];
    logic [15:0]        exp_y   [0:15];
    bit                 exp_err;

    logic [3:0]  wr_addr [$];
    logic [15:0] wr_data [$];
    int          wr_cyc  [$];
    int          done_cyc[$];

    spmv_csr_engine_if mem_if ();

    spmv_csr_engine dut (
        .i_clk   (clk),
        .i_rstn  (rstn),
        .i_start (start),
        .o_busy  (busy),
        .o_done  (done),
        .o_err   (err),
        .mem     (mem_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_if.o_rp_rd) mem_if.i_rp_data <= rp_mem[mem_if.o_rp_addr];
        if (mem_if.o_nz_rd) begin
            mem_if.i_val <= val_mem[mem_if.o_nz_addr];
            mem_if.i_col <= col_mem[mem_if.o_nz_addr];
        end
        if (mem_if.o_x_rd) mem_if.i_x <= x_mem[mem_if.o_x_addr];
    end

    always @(negedge clk) begin
        if (mem_if.o_y_we) begin
            wr_addr.push_back(mem_if.o_y_addr);
            wr_data.push_back(mem_if.o_y_data);
            wr_cyc.push_back(cyc);
        end
        if (done) done_cyc.push_back(cyc);
    end

    function automatic logic [15:0] narrow(input longint a);
`ifdef SPMV_SAT_EN
        if (a > 32767) return 16'h7FFF;
        if (a < -32768) return 16'h8000;
`endif
        return a[15:0];
    endfunction

    // Reference: walk the rows, a row pointer below the current position is an error row yielding 0.
    function automatic void model();
        int     k;
        int     e;
        longint acc;
        k = int'(rp_mem[0]);
        exp_err = 1'b0;
        for (int r = 0; r < 16; r++) begin
            e = int'(rp_mem[r+1]);
            acc = 0;
            if (e < k) begin
                exp_err = 1'b1;
                e = k;
            end
            for (int j = k; j < e; j++) acc += longint'(val_mem[j]) * longint'(x_mem[col_mem[j]]);
            exp_y[r] = narrow(acc);
            k = e;
        end
    endfunction

    task automatic gen_matrix(input bit force_row7);
        int cnt;
        rp_mem[0] = 9'($urandom_range(0, 3));
        for (int r = 0; r < 16; r++) begin
            cnt = (force_row7 && r == 7) ? $urandom_range(1, 4) : $urandom_range(0, 4);
            rp_mem[r+1] = rp_mem[r] + 9'(cnt);
        end
        for (int j = 0; j < 256; j++) begin
            val_mem[j] = 16'($urandom);
            col_mem[j] = 4'($urandom);
        end
        for (int i = 0; i < 16; i++) x_mem[i] = 16'($urandom);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic run_to_done(input int budget, output bit ok);
        clear_log();
        start = 1'b1;
        start_edge = cyc + 1;
        step();
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done_cyc.size() > 0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        step();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        start = 1'b0;
        repeat (3) step();
        checks++;
        if ({busy, done, err} !== 3'b000) begin
            failures++;
            $display("FAIL reset_status got=%b exp=000", {busy, done, err});
        end
        checks++;
        if ({mem_if.o_rp_rd, mem_if.o_nz_rd, mem_if.o_x_rd, mem_if.o_y_we} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=0000",
                     {mem_if.o_rp_rd, mem_if.o_nz_rd, mem_if.o_x_rd, mem_if.o_y_we});
        end
        checks++;
        if ({mem_if.o_rp_addr, mem_if.o_nz_addr, mem_if.o_x_addr, mem_if.o_y_addr, mem_if.o_y_data} !== '0) begin
            failures++;
            $display("FAIL reset_addr_data got=%h exp=0",
                     {mem_if.o_rp_addr, mem_if.o_nz_addr, mem_if.o_x_addr, mem_if.o_y_addr, mem_if.o_y_data});
        end
        rstn = 1'b1;
        repeat (4) step();
        checks++;
        if (busy !== 1'b0 || mem_if.o_rp_rd !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset busy=%b rp_rd=%b exp=0 0", busy, mem_if.o_rp_rd);
        end
    endtask

    task automatic test_identity();
        bit ok;
        for (int r = 0; r <= 16; r++) rp_mem[r] = 9'(r);
        for (int j = 0; j < 256; j++) begin
            val_mem[j] = (j < 16) ? 16'sd1 : 16'sd0;
            col_mem[j] = 4'(j);
        end
        for (int i = 0; i < 16; i++) x_mem[i] = 16'(i);
        run_to_done(2000, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL identity_timeout got=no_done exp=done"); end
        checks++;
        if (wr_addr.size() != 16) begin
            failures++;
            $display("FAIL identity_writes got=%0d exp=16", wr_addr.size());
        end
        for (int r = 0; r < wr_addr.size() && r < 16; r++) begin
            checks++;
            if (wr_addr[r] !== 4'(r) || wr_data[r] !== 16'(r)) begin
                failures++;
                $display("FAIL identity_row%0d got=%0d:%h exp=%0d:%h", r, wr_addr[r], wr_data[r], r, 16'(r));
            end
        end
        checks++;
        if (done_cyc.size() != 1 || err !== 1'b0) begin
            failures++;
            $display("FAIL identity_done_err got=%0d,%b exp=1,0", done_cyc.size(), err);
        end
    endtask

    task automatic test_empty_rows();
        bit ok;
        for (int r = 0; r <= 16; r++) rp_mem[r] = 9'd0;
        run_to_done(2000, ok);
        checks++;
        if (!ok || wr_addr.size() != 16) begin
            failures++;
            $display("FAIL empty_writes got=%0d exp=16", wr_addr.size());
        end
        checks++;
        if (wr_cyc.size() > 0 && wr_cyc[0] != start_edge + 3) begin
            failures++;
            $display("FAIL empty_first_write got=%0d exp=%0d", wr_cyc[0] - start_edge, 3);
        end
        for (int r = 1; r < wr_cyc.size() && r < 16; r++) begin
            checks++;
            if (wr_cyc[r] - wr_cyc[r-1] != 3 || wr_data[r] !== 16'h0 || wr_addr[r] !== 4'(r)) begin
                failures++;
                $display("FAIL empty_row%0d got=gap%0d:%0d:%h exp=gap3:%0d:0000",
                         r, wr_cyc[r] - wr_cyc[r-1], wr_addr[r], wr_data[r], r);
            end
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != start_edge + 49) begin
            failures++;
            $display("FAIL empty_done_time got=%0d exp=49", done_cyc.size() > 0 ? done_cyc[0] - start_edge : -1);
        end
    endtask

    task automatic test_saturation();
        bit ok;
        logic [15:0] want;
`ifdef SPMV_SAT_EN
        want = 16'h7FFF;
`else
        want = 16'h0004;
`endif
        rp_mem[0] = 9'd0;
        for (int r = 1; r <= 16; r++) rp_mem[r] = 9'd4;
        for (int j = 0; j < 4; j++) begin
            val_mem[j] = 16'h7FFF;
            col_mem[j] = 4'(j);
            x_mem[j]   = 16'h7FFF;
        end
        run_to_done(2000, ok);
        checks++;
        if (!ok || wr_data.size() != 16) begin
            failures++;
            $display("FAIL sat_writes got=%0d exp=16", wr_data.size());
        end else begin
            checks++;
            if (wr_data[0] !== want) begin
                failures++;
                $display("FAIL sat_row0 got=%h exp=%h", wr_data[0], want);
            end
            checks++;
            if (wr_data[1] !== 16'h0 || wr_data[15] !== 16'h0) begin
                failures++;
                $display("FAIL sat_other_rows got=%h,%h exp=0000,0000", wr_data[1], wr_data[15]);
            end
        end
    endtask

    task automatic test_malformed();
        bit ok;
        gen_matrix(1'b0);
        rp_mem[0] = 9'd0; rp_mem[1] = 9'd1; rp_mem[2] = 9'd3; rp_mem[3] = 9'd5; rp_mem[4] = 9'd2;
        for (int r = 5; r <= 16; r++) rp_mem[r] = 9'(5 + 2 * (r - 4));
        model();
        run_to_done(2000, ok);
        checks++;
        if (!ok || wr_data.size() != 16) begin
            failures++;
            $display("FAIL err_writes got=%0d exp=16", wr_data.size());
        end
        for (int r = 0; r < wr_data.size() && r < 16; r++) begin
            checks++;
            if (wr_data[r] !== exp_y[r] || (r == 3 && wr_data[r] !== 16'h0)) begin
                failures++;
                $display("FAIL err_row%0d got=%h exp=%h", r, wr_data[r], exp_y[r]);
            end
        end
        repeat (3) step();
        checks++;
        if (err !== 1'b1 || exp_err !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky got=%b exp=1", err);
        end
        gen_matrix(1'b0);
        model();
        clear_log();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_clear_on_start got=%b exp=0", err);
        end
        for (int i = 0; i < 2000 && done_cyc.size() == 0; i++) step();
        checks++;
        if (done_cyc.size() != 1 || wr_data.size() != 16) begin
            failures++;
            $display("FAIL err_followup got=%0d writes exp=16", wr_data.size());
        end else if (wr_data[15] !== exp_y[15]) begin
            failures++;
            $display("FAIL err_followup_row15 got=%h exp=%h", wr_data[15], exp_y[15]);
        end
        step();
    endtask

    task automatic test_random();
        bit ok;
        for (int it = 0; it < 4; it++) begin
            gen_matrix(1'b0);
            model();
            run_to_done(2000, ok);
            checks++;
            if (!ok || wr_data.size() != 16 || done_cyc.size() != 1 || err !== exp_err) begin
                failures++;
                $display("FAIL rand%0d_run got=%0d,%0d,%b exp=16,1,%b", it, wr_data.size(), done_cyc.size(), err, exp_err);
            end
            for (int r = 0; r < wr_data.size() && r < 16; r++) begin
                checks++;
                if (wr_addr[r] !== 4'(r) || wr_data[r] !== exp_y[r]) begin
                    failures++;
                    $display("FAIL rand%0d_row%0d got=%0d:%h exp=%0d:%h", it, r, wr_addr[r], wr_data[r], r, exp_y[r]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        bit hit;
        gen_matrix(1'b1);
        model();
        clear_log();
        start = 1'b1;
        step();
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (wr_addr.size() == 7 && mem_if.o_x_rd) begin hit = 1'b1; break; end
            step();
        end
        checks++;
        if (!hit) begin failures++; $display("FAIL midreset_reach_row7 got=%0d writes exp=7", wr_addr.size()); end
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        checks++;
        if ({busy, done, mem_if.o_y_we, mem_if.o_x_rd, mem_if.o_nz_rd, mem_if.o_rp_rd} !== 6'b0) begin
            failures++;
            $display("FAIL midreset_outputs got=%b exp=000000",
                     {busy, done, mem_if.o_y_we, mem_if.o_x_rd, mem_if.o_nz_rd, mem_if.o_rp_rd});
        end
        repeat (2) step();
        rstn = 1'b1;
        repeat (10) step();
        checks++;
        if (wr_addr.size() != 7 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_quiet got=%0d writes busy=%b exp=7 0", wr_addr.size(), busy);
        end
        run_to_done(2000, ok);
        checks++;
        if (!ok || wr_data.size() != 16) begin
            failures++;
            $display("FAIL midreset_rerun got=%0d exp=16", wr_data.size());
        end
        for (int r = 0; r < wr_data.size() && r < 16; r++) begin
            checks++;
            if (wr_data[r] !== exp_y[r]) begin
                failures++;
                $display("FAIL midreset_row%0d got=%h exp=%h", r, wr_data[r], exp_y[r]);
            end
        end
    endtask

    task automatic test_start_held();
        gen_matrix(1'b0);
        model();
        clear_log();
        start = 1'b1;
        step();
        for (int i = 0; i < 2000 && done_cyc.size() == 0; i++) step();
        checks++;
        if (done_cyc.size() != 1 || wr_data.size() != 16) begin
            failures++;
            $display("FAIL held_first_run got=%0d writes exp=16", wr_data.size());
        end else if (wr_data[9] !== exp_y[9]) begin
            failures++;
            $display("FAIL held_row9 got=%h exp=%h", wr_data[9], exp_y[9]);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL held_idle_gap got=%b exp=0", busy); end
        step();
        checks++;
        if (busy !== 1'b1 || mem_if.o_rp_rd !== 1'b1 || mem_if.o_rp_addr !== 5'd0) begin
            failures++;
            $display("FAIL held_restart got=%b,%b,%0d exp=1,1,0", busy, mem_if.o_rp_rd, mem_if.o_rp_addr);
        end
        start = 1'b0;
        clear_log();
        for (int i = 0; i < 2000 && done_cyc.size() == 0; i++) step();
        checks++;
        if (done_cyc.size() != 1 || wr_data.size() != 16) begin
            failures++;
            $display("FAIL held_second_run got=%0d writes exp=16", wr_data.size());
        end else if (wr_data[0] !== exp_y[0] || wr_data[15] !== exp_y[15]) begin
            failures++;
            $display("FAIL held_second_rows got=%h,%h exp=%h,%h", wr_data[0], wr_data[15], exp_y[0], exp_y[15]);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_identity();
        test_empty_rows();
        test_saturation();
        test_malformed();
        test_random();
        test_reset_mid_run();
        test_start_held();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
